// File: rtl/turf_pkg.sv
// rtl/turf_pkg.sv - shared colour codes, default geometry and tally state enum for turf_tally
package turf_pkg;

  localparam logic [2:0] COLOR_P1   = 3'b001;
  localparam logic [2:0] COLOR_P2   = 3'b010;
  localparam logic [2:0] COLOR_P3   = 3'b100;
  localparam logic [2:0] COLOR_P4   = 3'b110;
  localparam logic [2:0] BACKGROUND = 3'b000;

  localparam int DEF_X_W     = 8;
  localparam int DEF_Y_W     = 7;
  localparam int DEF_X_MAX   = 157;
  localparam int DEF_Y_MAX   = 119;
  localparam int DEF_COLOR_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCAN,
    ST_DRAIN,
    ST_COMPARE,
    ST_DONE
  } tally_state_t;

  // A count can never exceed the number of addressable pixels.
  function automatic int count_w(input int x_w, input int y_w);
    return x_w + y_w;
  endfunction

endpackage

// File: rtl/turf_tally_if.sv
// rtl/turf_tally_if.sv - RAM read port, control and result bundle of turf_tally
interface turf_tally_if
  import turf_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int X_W         = DEF_X_W,
  parameter int Y_W         = DEF_Y_W,
  parameter int COLOR_W     = DEF_COLOR_W
);
  localparam int CNT_W = count_w(X_W, Y_W);
  localparam int WIN_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  logic                         start;
  logic [X_W+Y_W-1:0]           address;
  logic [COLOR_W-1:0]           rd_data;
  logic                         busy;
  logic                         done;
  logic [NUM_PLAYERS*CNT_W-1:0] counts;
  logic [WIN_W-1:0]             winner;
  logic                         tie;

  modport master (
    output start, rd_data,
    input  address, busy, done, counts, winner, tie
  );

  modport slave (
    input  start, rd_data,
    output address, busy, done, counts, winner, tie
  );

endinterface

// File: rtl/turf_argmax.sv
// rtl/turf_argmax.sv - one-player-per-cycle running max with explicit tie detection
module turf_argmax #(
  parameter int NUM_PLAYERS = 4,
  parameter int CNT_W       = 15,
  parameter int WIN_W       = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_PLAYERS*CNT_W-1:0] counts,
  output logic [WIN_W-1:0]             winner,
  output logic                         tie
);

  logic [CNT_W-1:0] cnt [NUM_PLAYERS];
  logic [WIN_W-1:0] idx, cur_idx, best_idx, nb_idx;
  logic [CNT_W-1:0] best, cur_val, nb;
  logic             active, tie_run, nt, last;

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      cnt[i] = counts[i*CNT_W +: CNT_W];
    end
  end

  // The start cycle seeds the running max with player 0; later cycles only
  // replace it on a strictly greater count, so the lowest index wins ties.
  always_comb begin
    cur_idx = start ? '0 : idx;
    cur_val = cnt[cur_idx];
    nb      = best;
    nb_idx  = best_idx;
    nt      = tie_run;
    if (start) begin
      nb     = cur_val;
      nb_idx = '0;
      nt     = 1'b0;
    end else if (cur_val > best) begin
      nb     = cur_val;
      nb_idx = cur_idx;
      nt     = 1'b0;
    end else if (cur_val == best) begin
      nt = 1'b1;
    end
    last = (cur_idx == WIN_W'(NUM_PLAYERS - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      best     <= '0;
      best_idx <= '0;
      tie_run  <= 1'b0;
      active   <= 1'b0;
      winner   <= '0;
      tie      <= 1'b0;
    end else if (start || active) begin
      best     <= nb;
      best_idx <= nb_idx;
      tie_run  <= nt;
      if (last) begin
        winner <= nb_idx;
        tie    <= nt;
        active <= 1'b0;
      end else begin
        idx    <= cur_idx + WIN_W'(1);
        active <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/turf_tally.sv
// rtl/turf_tally.sv - end-of-round paint tallier: scans the paint RAM, counts per colour, picks the winner
module turf_tally
  import turf_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int X_W         = DEF_X_W,
  parameter int Y_W         = DEF_Y_W,
  parameter int X_MAX       = DEF_X_MAX,
  parameter int Y_MAX       = DEF_Y_MAX,
  parameter int COLOR_W     = DEF_COLOR_W,
  parameter int RAM_LATENCY = 1,
  parameter logic [NUM_PLAYERS*COLOR_W-1:0] PLAYER_COLORS =
    {COLOR_P4, COLOR_P3, COLOR_P2, COLOR_P1}
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  turf_tally_if.slave  bus
);

  localparam int CNT_W  = count_w(X_W, Y_W);
  localparam int WIN_W  = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int STEP_W = 4;

  tally_state_t state, state_next;

  logic [X_W-1:0]               x;
  logic [Y_W-1:0]               y;
  logic [STEP_W-1:0]            step;
  logic [RAM_LATENCY-1:0]       vld;
  logic [RAM_LATENCY:0]         vld_ext;
  logic [NUM_PLAYERS*CNT_W-1:0] counts;
  logic                         last_pix, issue, cmp_start, busy, done;

  assign last_pix    = (x == X_W'(X_MAX)) && (y == Y_W'(Y_MAX));
  assign issue       = (state == ST_SCAN);
  assign vld_ext     = {vld, issue};
  assign cmp_start   = (state == ST_COMPARE) && (step == '0);
  assign bus.address = {x, y};
  assign bus.counts  = counts;
  assign bus.busy    = busy;
  assign bus.done    = done;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE:    if (bus.start) state_next = ST_CLEAR;
      ST_CLEAR:   state_next = ST_SCAN;
      ST_SCAN:    if (last_pix) state_next = ST_DRAIN;
      ST_DRAIN:   if (step == STEP_W'(RAM_LATENCY - 1)) state_next = ST_COMPARE;
      ST_COMPARE: if (step == STEP_W'(NUM_PLAYERS - 1)) state_next = ST_DONE;
      ST_DONE:    if (bus.start) state_next = ST_CLEAR;
      default:    state_next = ST_IDLE;
    endcase
    busy = (state == ST_CLEAR) || (state == ST_SCAN) ||
           (state == ST_DRAIN) || (state == ST_COMPARE);
    done = (state == ST_DONE);
  end

  // step restarts on every state change so DRAIN and COMPARE can share it.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      step   <= '0;
      vld    <= '0;
      counts <= '0;
    end else begin
      step <= (state_next != state) ? '0 : step + STEP_W'(1);
      vld  <= vld_ext[RAM_LATENCY-1:0];
      if (state == ST_CLEAR) begin
        x      <= '0;
        y      <= '0;
        counts <= '0;
      end else begin
        if (issue && !last_pix) begin
          if (y == Y_W'(Y_MAX)) begin
            y <= '0;
            x <= x + X_W'(1);
          end else begin
            y <= y + Y_W'(1);
          end
        end
        // The tag emerging from the valid pipeline marks rd_data as a real pixel.
        if (vld[RAM_LATENCY-1]) begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (bus.rd_data == PLAYER_COLORS[i*COLOR_W +: COLOR_W] &&
                counts[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
              counts[i*CNT_W +: CNT_W] <= counts[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
          end
        end
      end
    end
  end

  turf_argmax #(
    .NUM_PLAYERS (NUM_PLAYERS),
    .CNT_W       (CNT_W),
    .WIN_W       (WIN_W)
  ) u_argmax (
    .clk    (CLOCK_50),
    .reset  (reset),
    .start  (cmp_start),
    .counts (counts),
    .winner (bus.winner),
    .tie    (bus.tie)
  );

endmodule

// File: tb/tb_turf_tally.sv
// tb/tb_turf_tally.sv - directed self-checking bench for turf_tally
module tb_turf_tally;

  logic CLOCK_50 = 1'b0;
  logic reset_a  = 1'b1;
  logic reset_b  = 1'b1;
  logic reset_c  = 1'b1;
  int   n_total  = 0;
  int   n_pass   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  turf_tally_if ifa ();
  turf_tally_if ifb ();
  turf_tally_if ifc ();

  turf_tally #(.X_MAX(3), .Y_MAX(1), .RAM_LATENCY(1)) dut_a (
    .CLOCK_50 (CLOCK_50), .reset (reset_a), .bus (ifa));
  turf_tally #(.X_MAX(3), .Y_MAX(1), .RAM_LATENCY(3)) dut_b (
    .CLOCK_50 (CLOCK_50), .reset (reset_b), .bus (ifb));
  turf_tally dut_c (
    .CLOCK_50 (CLOCK_50), .reset (reset_c), .bus (ifc));

  // Small 4x2 board shared by the two small DUTs; index = x*2 + y.
  logic [2:0] mem_s [8];
  logic [2:0] pb [3];

  function automatic logic [2:0] mem_rd(input logic [14:0] a);
    if (a[14:7] < 8'd4 && a[6:0] < 7'd2) return mem_s[a[14:7]*2 + a[6:0]];
    return 3'b000;
  endfunction

  always @(posedge CLOCK_50) begin
    ifa.rd_data <= mem_rd(ifa.address);
    pb[0]       <= mem_rd(ifb.address);
    pb[1]       <= pb[0];
    pb[2]       <= pb[1];
  end
  assign ifb.rd_data = pb[2];
  assign ifc.rd_data = 3'b001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_start(input int s, input logic v);
    case (s)
      0:       ifa.start = v;
      1:       ifb.start = v;
      default: ifc.start = v;
    endcase
  endtask

  function automatic logic get_done(input int s);
    case (s)
      0:       return ifa.done;
      1:       return ifb.done;
      default: return ifc.done;
    endcase
  endfunction

  function automatic logic get_busy(input int s);
    case (s)
      0:       return ifa.busy;
      1:       return ifb.busy;
      default: return ifc.busy;
    endcase
  endfunction

  function automatic logic [31:0] get_count(input int s, input int p);
    logic [59:0] c;
    case (s)
      0:       c = ifa.counts;
      1:       c = ifb.counts;
      default: c = ifc.counts;
    endcase
    return 32'((c >> (p * 15)) & 60'h7fff);
  endfunction

  task automatic check_res(input int s, input int c0, input int c1, input int c2,
                           input int c3, input int w, input int t);
    logic [1:0] win;
    logic       tie;
    case (s)
      0:       begin win = ifa.winner; tie = ifa.tie; end
      1:       begin win = ifb.winner; tie = ifb.tie; end
      default: begin win = ifc.winner; tie = ifc.tie; end
    endcase
    chk("count_p0", get_count(s, 0), c0);
    chk("count_p1", get_count(s, 1), c1);
    chk("count_p2", get_count(s, 2), c2);
    chk("count_p3", get_count(s, 3), c3);
    chk("winner", 32'(win), w);
    chk("tie", 32'(tie), t);
  endtask

  // Pulses start, then counts edges until done; optionally pulses start again
  // at cycle extra_at and checks the small-board address order.
  task automatic go(input int s, input int exp_lat, input bit chk_addr, input int extra_at);
    int cyc;
    @(negedge CLOCK_50);
    set_start(s, 1'b1);
    @(posedge CLOCK_50);
    #1;
    set_start(s, 1'b0);
    chk("done_cleared_after_start", 32'(get_done(s)), 0);
    chk("busy_after_start", 32'(get_busy(s)), 1);
    cyc = 0;
    while (!get_done(s) && cyc < exp_lat + 20) begin
      @(posedge CLOCK_50);
      #1;
      cyc++;
      set_start(s, cyc == extra_at);
      if (chk_addr && cyc >= 1 && cyc <= 8)
        chk("scan_address", 32'(ifa.address), ((cyc - 1) / 2) * 128 + (cyc - 1) % 2);
    end
    set_start(s, 1'b0);
    chk("done_latency", cyc, exp_lat);
    chk("busy_at_done", 32'(get_busy(s)), 0);
  endtask

  initial begin
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    ifc.start = 1'b0;
    mem_s = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    repeat (2) @(posedge CLOCK_50);
    #1;
    reset_a = 1'b0;
    reset_b = 1'b0;
    reset_c = 1'b0;
    chk("reset_address", 32'(ifa.address), 0);
    chk("reset_busy", 32'(ifa.busy), 0);
    chk("reset_done", 32'(ifa.done), 0);
    check_res(0, 0, 0, 0, 0, 0, 0);

    // Empty board: address order, latency, all-zero tie.
    go(0, 14, 1'b1, -1);
    check_res(0, 0, 0, 0, 0, 0, 1);

    // 5 x 100, 2 x 001, 1 x 111 (ignored).
    mem_s = '{3'b100, 3'b100, 3'b001, 3'b100, 3'b111, 3'b100, 3'b001, 3'b100};
    go(0, 14, 1'b0, -1);
    check_res(0, 2, 0, 5, 0, 2, 0);

    // 3 x 010 vs 3 x 110: lowest index wins with tie, at latency 1 and 3.
    mem_s = '{3'b010, 3'b110, 3'b010, 3'b110, 3'b000, 3'b010, 3'b110, 3'b000};
    go(0, 14, 1'b0, -1);
    check_res(0, 0, 3, 0, 3, 1, 1);
    go(1, 16, 1'b0, -1);
    check_res(1, 0, 3, 0, 3, 1, 1);

    // Reset mid-scan discards everything, including the previous result.
    mem_s = '{3'b100, 3'b100, 3'b001, 3'b100, 3'b111, 3'b100, 3'b001, 3'b100};
    @(negedge CLOCK_50);
    ifa.start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    ifa.start = 1'b0;
    repeat (5) @(posedge CLOCK_50);
    #1;
    reset_a = 1'b1;
    @(posedge CLOCK_50);
    #1;
    reset_a = 1'b0;
    chk("abort_busy", 32'(ifa.busy), 0);
    chk("abort_address", 32'(ifa.address), 0);
    check_res(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLOCK_50);
      #1;
      chk("abort_done_low", 32'(ifa.done), 0);
    end
    go(0, 14, 1'b0, -1);
    check_res(0, 2, 0, 5, 0, 2, 0);

    // start during SCAN is ignored; start in DONE restarts with new data.
    go(0, 14, 1'b0, 4);
    check_res(0, 2, 0, 5, 0, 2, 0);
    mem_s = '{3'b010, 3'b110, 3'b010, 3'b110, 3'b000, 3'b010, 3'b110, 3'b000};
    go(0, 14, 1'b0, -1);
    check_res(0, 0, 3, 0, 3, 1, 1);

    // Full default board painted by player 0.
    go(2, 18966, 1'b0, -1);
    check_res(2, 18960, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/turf_tally.md
Name: turf_tally

Overview:
- Parametrised end-of-round paint tallier for N players.
- Scans every valid framebuffer pixel through the paint RAM's synchronous read port and counts pixels per player colour.
- Then determines the winner, reporting ties explicitly.
- Sits between the paint RAM read port and the score/winner display; started once when the round timer expires.

Parameters:
NUM_PLAYERS, 4, number of players/colours tallied (2..8)
X_W, 8, x-coordinate width (address upper field)
Y_W, 7, y-coordinate width (address lower field)
X_MAX, 157, last valid x
Y_MAX, 119, last valid y
COLOR_W, 3, RAM data width
RAM_LATENCY, 1, cycles from address presented to rd_data valid (1..3)
PLAYER_COLORS, {3'b110,3'b100,3'b010,3'b001}, packed colour codes; player i uses slice i (player 0 = 3'b001)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: begin tally
address  out  X_W+Y_W  RAM read address {x,y}
rd_data  in  COLOR_W  RAM read data, RAM_LATENCY cycles after address
busy  out  1  high from the cycle after an accepted start until done rises
done  out  1  level; high once results are valid, held until next accepted start or reset
counts  out  NUM_PLAYERS*(X_W+Y_W)  packed per-player pixel counts; player i at slice i
winner  out  max(1,$clog2(NUM_PLAYERS))  index of the player with the highest count
tie  out  1  another player equals the winner's count

Behaviour:
- Reset (synchronous, active-high; the only clock is CLOCK_50): state IDLE; address=0; busy=0; done=0; counts all 0; winner=0; tie=0; valid pipeline cleared.
- Reset wins over every other input in the same cycle; reset mid-scan aborts immediately, no partial results kept.
- States: IDLE, CLEAR, SCAN, DRAIN, COMPARE, DONE.
- IDLE/DONE: start=1 -> CLEAR, done<=0, busy<=1. start in any other state is ignored.
- CLEAR (1 cycle): all counts <= 0; x=0, y=0 -> SCAN.
- SCAN: issues one address per cycle, address={x,y}.
  - y increments 0..Y_MAX, then y=0 and x++. Only valid pixels are issued (no y>Y_MAX).
  - P=(X_MAX+1)*(Y_MAX+1) cycles total.
  - After issuing {X_MAX,Y_MAX} -> DRAIN.
- Valid pipeline: a RAM_LATENCY-deep shift register tags each issued address.
  - When the tagged bit emerges, rd_data is compared against each PLAYER_COLORS slice. A match increments that player's count.
  - Non-matching codes (e.g. 0 background) are ignored.
  - Counts saturate at all-ones.
- DRAIN: RAM_LATENCY cycles so in-flight reads retire -> COMPARE.
- COMPARE: NUM_PLAYERS cycles, one player per cycle, index 0 upward.
  - Running max: strictly greater replaces the best and clears tie; equal sets tie. Lowest index wins equal counts.
  - winner/tie are updated on the final compare cycle -> DONE.
- DONE: done=1, busy=0; counts/winner/tie are held stable.
- Latency: done rises exactly 1+P+RAM_LATENCY+NUM_PLAYERS cycles after the edge that accepted start.
- All-zero board: winner=0, tie=1 (NUM_PLAYERS>1).
- address holds its last value outside SCAN; its value is don't-care for the RAM when not scanning.

Decomposition:
- Shared package turf_pkg: player colour codes (P1..P4 = 001, 010, 100, 110), BACKGROUND=000, default X_W/Y_W/X_MAX/Y_MAX, count width function X_W+Y_W.
- Tally state enum in turf_pkg.
- One sub-module: turf_argmax — sequential one-per-cycle max/tie finder over the packed counts, started by a pulse, returns winner/tie.

Test Plan:
1. Small params X_MAX=3,Y_MAX=1,RAM_LATENCY=1, RAM model all 0, start -> 8 addresses {0,0},{0,1},{1,0}..{3,1}; done after 1+8+1+4=14 cycles; counts all 0; winner=0; tie=1.
2. Same params, RAM: 5 pixels 3'b100, 2 pixels 3'b001, 1 pixel 3'b111 -> counts p0=2,p1=0,p2=5,p3=0; winner=2; tie=0; 3'b111 ignored.
3. RAM: 3 pixels 3'b010 and 3 pixels 3'b110 -> winner=1, tie=1; repeat with RAM_LATENCY=3 -> same counts, done at cycle 16.
4. Reset asserted mid-SCAN (cycle 5), start reissued -> done=0 throughout the abort; fresh tally gives the correct counts with no residue.
5. start pulsed during SCAN and again in DONE -> the first is ignored (latency unchanged); the second clears done next cycle and restarts, with results recomputed.
6. Default params, full board of 3'b001 -> counts p0=18960, others 0; winner=0; done at 1+18960+1+4 cycles.
